// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - receive FIFO behind a UART receiver, fed by its frame-complete strobe
//
// Purpose: each rx_ready_in high pulse stores one byte; a consumer drains bytes
// first-word fall-through with a valid/ready handshake.
//
// Ports:
//   clock_out     in   block clock (UART oversampling clock), rising edge
//   nreset        in   asynchronous active-low reset
//   rx_ready_in   in   frame-complete level from the receiver (may be asynchronous)
//   rx_data_in    in   received byte, stable from rx_ready_in fall to the next stop bit
//   clear         in   synchronous flush of contents and overflow flag
//   ready_in      in   consumer accepts data_out this cycle
//   valid_out     out  data_out holds a stored byte
//   data_out      out  oldest stored byte
//   count_out     out  occupancy, 0..DEPTH
//   full_out      out  count_out == DEPTH
//   overflow_out  out  sticky: a byte was dropped because the FIFO was full
module uart_rx_fifo #(
    parameter int  BYTESIZES = 8,
    parameter int  DEPTH     = 16,
    localparam int CW        = $clog2(DEPTH) + 1
) (
    input  logic                 clock_out,
    input  logic                 nreset,
    input  logic                 rx_ready_in,
    input  logic [BYTESIZES-1:0] rx_data_in,
    input  logic                 clear,
    input  logic                 ready_in,
    output logic                 valid_out,
    output logic [BYTESIZES-1:0] data_out,
    output logic [CW-1:0]        count_out,
    output logic                 full_out,
    output logic                 overflow_out
);

    localparam int AW = $clog2(DEPTH);

    logic                 s1_q, s1_d;
    logic                 s2_q, s2_d;
    logic                 d_q, d_d;
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 overflow_q, overflow_d;
    logic [BYTESIZES-1:0] mem_q [DEPTH];

    logic                 fall;
    logic                 pop;
    logic                 full;
    logic                 wr_en;

    always_comb begin
        s1_d       = rx_ready_in;
        s2_d       = s1_q;
        d_d        = s2_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        wr_en      = 1'b0;

        // Falling edge of the synchronized strobe: one event per pulse,
        // however long the stop bit lasts.
        fall = d_q & ~s2_q;
        full = (count_q == CW'(DEPTH));
        pop  = (count_q != '0) & ready_in;

        if (clear) begin
            // Clear wins over a coincident push or pop; a discarded push
            // does not count as an overflow.
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            // A pop on the same edge frees the slot, so a full FIFO still
            // accepts the byte.
            if (fall && (!full || pop)) begin
                wr_en    = 1'b1;
                wr_ptr_d = wr_ptr_q + AW'(1);
            end else if (fall) begin
                overflow_d = 1'b1;
            end

            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end

            case ({wr_en, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock_out or negedge nreset) begin
        if (!nreset) begin
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            d_q        <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            d_q        <= d_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage carries no reset; validity is tracked by count_q alone.
    always_ff @(posedge clock_out) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= rx_data_in;
        end
    end

    assign valid_out    = (count_q != '0);
    assign data_out     = mem_q[rd_ptr_q];
    assign count_out    = count_q;
    assign full_out     = full;
    assign overflow_out = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - scoreboard bench for uart_rx_fifo
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;
    localparam int BW    = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clock_out   = 1'b0;
    logic          nreset      = 1'b0;
    logic          rx_ready_in = 1'b0;
    logic [BW-1:0] rx_data_in  = '0;
    logic          clear       = 1'b0;
    logic          ready_in    = 1'b0;
    logic          valid_out;
    logic [BW-1:0] data_out;
    logic [CW-1:0] count_out;
    logic          full_out;
    logic          overflow_out;

    uart_rx_fifo #(.BYTESIZES(BW), .DEPTH(DEPTH)) dut (
        .clock_out    (clock_out),
        .nreset       (nreset),
        .rx_ready_in  (rx_ready_in),
        .rx_data_in   (rx_data_in),
        .clear        (clear),
        .ready_in     (ready_in),
        .valid_out    (valid_out),
        .data_out     (data_out),
        .count_out    (count_out),
        .full_out     (full_out),
        .overflow_out (overflow_out)
    );

    always #5 clock_out = ~clock_out;

    int            checks = 0;
    int            errors = 0;
    logic [BW-1:0] exp_q[$];
    int            m_count = 0;
    bit            m_ovf = 0;
    bit            prev_rx = 0;
    int            cd = 0;
    bit            mon_en = 0;
    bit            rand_ready = 0;
    bit            push_now;
    bit            pop_now;
    logic [BW-1:0] exp_byte;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    // Reference model: a byte lands in the FIFO on the 3rd edge after the
    // strobe falls; the queue holds the bytes a consumer should see.
    always @(posedge clock_out or negedge nreset) begin
        if (!nreset) begin
            exp_q.delete();
            m_count = 0;
            m_ovf   = 0;
            cd      = 0;
            prev_rx = rx_ready_in;
        end else begin
            push_now = (cd == 1);
            if (cd != 0) cd--;
            if (prev_rx && !rx_ready_in) cd = 2;
            prev_rx = rx_ready_in;
            pop_now = (m_count != 0) && ready_in;
            if (clear) begin
                exp_q.delete();
                m_count = 0;
                m_ovf   = 0;
            end else begin
                if (push_now) begin
                    if (m_count < DEPTH || pop_now) begin
                        exp_q.push_back(rx_data_in);
                        m_count++;
                    end else begin
                        m_ovf = 1;
                    end
                end
                if (pop_now) m_count--;
            end
        end
    end

    // Monitor: on every accepted transfer take the oldest expected byte.
    always @(negedge clock_out) begin
        if (mon_en) begin
            if (valid_out && ready_in && !clear && nreset) begin
                if (exp_q.size() == 0) begin
                    chk("pop_unexpected", 32'd1, 32'd0);
                end else begin
                    exp_byte = exp_q.pop_front();
                    chk("pop_data", 32'(data_out), 32'(exp_byte));
                end
            end
            chk("valid", 32'(valid_out), 32'(m_count != 0));
            chk("count", 32'(count_out), 32'(m_count));
            chk("full", 32'(full_out), 32'(m_count == DEPTH));
            chk("overflow", 32'(overflow_out), 32'(m_ovf));
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock_out);
        #1;
        if (rand_ready) ready_in = ($urandom_range(0, 15) == 0);
    endtask

    task automatic send_frame(input logic [BW-1:0] b, input int hi);
        rx_data_in  = b;
        rx_ready_in = 1'b1;
        repeat (hi) tick();
        rx_ready_in = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic fill_0_15();
        for (int i = 0; i < 16; i++) begin
            send_frame(8'(i), 4);
            repeat (4) tick();
        end
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_count", 32'(count_out), 32'd0);
        chk("rst_valid", 32'(valid_out), 32'd0);
        chk("rst_full", 32'(full_out), 32'd0);
        chk("rst_overflow", 32'(overflow_out), 32'd0);
        mon_en = 1;
        nreset = 1'b1;
        repeat (2) tick();

        // single byte and latency
        send_frame(8'hA5, 16);
        tick();
        tick();
        chk("lat_early_valid", 32'(valid_out), 32'd0);
        tick();
        chk("lat_valid", 32'(valid_out), 32'd1);
        chk("lat_data", 32'(data_out), 32'hA5);
        chk("lat_count", 32'(count_out), 32'd1);
        ready_in = 1'b1;
        tick();
        ready_in = 1'b0;
        chk("single_pop_count", 32'(count_out), 32'd0);
        chk("single_pop_valid", 32'(valid_out), 32'd0);

        // fill, overflow, clear
        fill_0_15();
        chk("fill_full", 32'(full_out), 32'd1);
        chk("fill_count", 32'(count_out), 32'd16);
        chk("fill_ovf", 32'(overflow_out), 32'd0);
        send_frame(8'hFF, 4);
        repeat (4) tick();
        chk("ovf_flag", 32'(overflow_out), 32'd1);
        chk("ovf_count", 32'(count_out), 32'd16);
        chk("ovf_head", 32'(data_out), 32'h00);
        pulse_clear();
        chk("clr_count", 32'(count_out), 32'd0);
        chk("clr_ovf", 32'(overflow_out), 32'd0);

        // full with coincident push and pop
        fill_0_15();
        send_frame(8'hFF, 4);
        tick();
        tick();
        ready_in = 1'b1;
        tick();
        ready_in = 1'b0;
        chk("fullpp_count", 32'(count_out), 32'd16);
        chk("fullpp_ovf", 32'(overflow_out), 32'd0);
        ready_in = 1'b1;
        repeat (15) tick();
        chk("fullpp_last_data", 32'(data_out), 32'hFF);
        chk("fullpp_last_count", 32'(count_out), 32'd1);
        tick();
        ready_in = 1'b0;
        chk("fullpp_drained", 32'(count_out), 32'd0);

        // wrap-around with a consumer always ready
        ready_in = 1'b1;
        for (int i = 0; i < 40; i++) begin
            send_frame(8'(8'h10 + i), 3);
            repeat (3) tick();
            chk("wrap_count_le2", 32'(count_out <= 2), 32'd1);
        end
        tick();
        ready_in = 1'b0;
        chk("wrap_drained", 32'(count_out), 32'd0);

        // reset mid-stream
        for (int i = 0; i < 5; i++) begin
            send_frame(8'(8'h50 + i), 4);
            repeat (4) tick();
        end
        chk("mid_count5", 32'(count_out), 32'd5);
        nreset = 1'b0;
        #1;
        chk("mid_rst_count", 32'(count_out), 32'd0);
        chk("mid_rst_valid", 32'(valid_out), 32'd0);
        tick();
        nreset = 1'b1;
        tick();
        send_frame(8'h3C, 16);
        repeat (3) tick();
        chk("mid_after_count", 32'(count_out), 32'd1);
        chk("mid_after_data", 32'(data_out), 32'h3C);
        ready_in = 1'b1;
        tick();
        ready_in = 1'b0;
        chk("mid_after_empty", 32'(count_out), 32'd0);

        // reset released while the strobe is high
        nreset      = 1'b0;
        rx_data_in  = 8'h5A;
        rx_ready_in = 1'b1;
        tick();
        tick();
        nreset = 1'b1;
        repeat (10) tick();
        chk("rsthi_no_push", 32'(count_out), 32'd0);
        rx_ready_in = 1'b0;
        tick();
        tick();
        chk("rsthi_early", 32'(valid_out), 32'd0);
        tick();
        chk("rsthi_count", 32'(count_out), 32'd1);
        chk("rsthi_data", 32'(data_out), 32'h5A);
        ready_in = 1'b1;
        tick();
        ready_in = 1'b0;

        // randomized traffic with sparse consumer and occasional clears
        rand_ready = 1;
        for (int i = 0; i < 60; i++) begin
            send_frame(8'($urandom_range(0, 255)), $urandom_range(3, 10));
            repeat ($urandom_range(3, 8)) tick();
            if ($urandom_range(0, 9) == 0) pulse_clear();
        end
        rand_ready = 0;
        repeat (4) tick();
        ready_in = 1'b1;
        repeat (24) tick();
        ready_in = 1'b0;
        tick();
        chk("final_empty", 32'(count_out), 32'd0);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 The block SHALL have parameter BYTESIZES, default 8, giving the width of one received byte in bits.
REQ-002 The block SHALL have parameter DEPTH, default 16, giving the number of FIFO entries; legal values are powers of two, 2 or greater.
REQ-003 The block SHALL define localparam CW = $clog2(DEPTH)+1 as the occupancy counter width.
REQ-004 Port clock_out, input, 1 bit: block clock (UART oversampling clock); all state updates on its rising edge.
REQ-005 Port nreset, input, 1 bit: reset, asynchronous, active-low.
REQ-006 Port rx_ready_in, input, 1 bit: frame-complete level from uart_rx ready_rx_out; may be asynchronous to clock_out; high for the stop-bit period.
REQ-007 Port rx_data_in, input, BYTESIZES bits: received byte from uart_rx data_rx_out; stable from rx_ready_in fall until the next frame's stop bit.
REQ-008 Port clear, input, 1 bit: synchronous flush of the FIFO and status.
REQ-009 Port ready_in, input, 1 bit: consumer accepts data_out in this cycle.
REQ-010 Port valid_out, output, 1 bit: data_out holds a valid byte.
REQ-011 Port data_out, output, BYTESIZES bits: oldest stored byte (first-word fall-through).
REQ-012 Port count_out, output, CW bits: current occupancy, 0..DEPTH.
REQ-013 Port full_out, output, 1 bit: count_out == DEPTH.
REQ-014 Port overflow_out, output, 1 bit: sticky flag; a byte was dropped.

Function
REQ-015 rx_ready_in SHALL pass through a two-flop synchronizer (s1, s2), then a delay flop d; frame event fall = d & ~s2.
REQ-016 A push SHALL occur on the clock_out edge where fall is 1, writing rx_data_in into mem[wr_ptr]; exactly one push per rx_ready_in high pulse, regardless of pulse length.
REQ-017 A pop SHALL occur on the edge where valid_out & ready_in is 1, advancing rd_ptr by one.
REQ-018 Pointers SHALL be log2(DEPTH) bits and wrap from DEPTH-1 to 0 with no gap.
REQ-019 valid_out SHALL equal (count_out != 0); data_out SHALL equal mem[rd_ptr] combinationally; data_out is don't-care when valid_out is 0.
REQ-020 Push with count < DEPTH: store the byte, wr_ptr+1, count+1 (count unchanged if a pop occurs the same edge).
REQ-021 Push with count == DEPTH and a pop on the same edge: store the byte, both pointers advance, count stays DEPTH, no overflow.
REQ-022 Push with count == DEPTH and no pop: drop the byte, leave memory/pointers/count unchanged, set overflow_out to 1.
REQ-023 Pop with no push: count-1; pop with count 0 is impossible (valid_out 0).
REQ-024 Latency: a byte SHALL appear on data_out with valid_out=1 on the 3rd clock_out rising edge after rx_ready_in falls (2 sync + 1 edge stage), when the FIFO was empty.
REQ-025 clear=1 SHALL, at the next edge, set wr_ptr, rd_ptr and count to 0 and overflow_out to 0; it has priority over push and pop on the same edge, and a coincident push is discarded without setting overflow.
REQ-026 The synchronizer and edge flops SHALL keep running during clear.
REQ-027 overflow_out SHALL be cleared only by clear or reset.
REQ-028 Memory contents SHALL need no reset; only pointers, count, flags and synchronizer flops are reset.

Reset
REQ-029 On nreset low, asynchronously: s1, s2, d = 0; wr_ptr, rd_ptr = 0; count_out = 0; valid_out = 0; full_out = 0; overflow_out = 0.
REQ-030 Deasserting reset while rx_ready_in is high SHALL NOT create a push until that pulse ends; the block pushes once when it falls.
REQ-031 Reset asserted mid-operation SHALL discard all stored bytes; no push or pop occurs while nreset is low.

Verification
REQ-032 Single byte: rx_data_in=8'hA5, rx_ready_in high 16 cycles then low, ready_in=0 -> 3rd edge after fall: valid_out=1, data_out=8'hA5, count_out=1; ready_in=1 for one cycle -> count_out=0, valid_out=0.
REQ-033 Fill and order: push 8'h00..8'h0F with ready_in=0 -> full_out=1, count_out=16, overflow_out=0; then ready_in=1 -> pops return 8'h00..8'h0F in order.
REQ-034 Overflow: FIFO full, push 8'hFF with no pop -> overflow_out=1, count_out=16, head still 8'h00; clear for 1 cycle -> count_out=0, overflow_out=0.
REQ-035 Full with simultaneous pop/push: FIFO full, ready_in=1 on the push edge -> count_out stays 16, overflow_out=0, 8'hFF is last out.
REQ-036 Wrap: 40 push/pop pairs with data 8'h10+i -> every byte returned in order, count_out never exceeds 2.
REQ-037 Reset mid-stream: 5 bytes stored, nreset pulsed low -> count_out=0, valid_out=0 immediately; next frame 8'h3C is read back as the only byte.
